// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: upstream command stage for an SR flip-flop.
// Raw set/clear requests are synchronized, debounced, turned into one-shot
// pending commands and arbitrated into clean, registered, mutually exclusive
// s/r pulses. s and r are never high together, and every command is followed
// by a GAP cycle and an IDLE cycle before the next one can start.
//
// Ports:
//   clk       - clock, all state updates on posedge
//   reset     - asynchronous active-low reset
//   set_in    - raw set request (asynchronous, may bounce)
//   clr_in    - raw clear request (asynchronous, may bounce)
//   s         - set command, high for HOLD_CYCLES cycles per set command
//   r         - reset command, high for HOLD_CYCLES cycles per clear command
//   busy      - high whenever the FSM is not idle
//   conflict  - one-cycle pulse when both requests were pending at arbitration
//   cmd_count - number of commands issued, wraps at 255
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter bit          CLR_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] cmd_count
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDriveS = 2'd1;
  localparam logic [1:0] StDriveR = 2'd2;
  localparam logic [1:0] StGap    = 2'd3;

  localparam logic [7:0] DebMax  = 8'(DEB_CYCLES);
  localparam logic [7:0] HoldMax = 8'(HOLD_CYCLES - 1);

  // Channel index 0 is set, index 1 is clear.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] stable_q, stable_d;
  logic [1:0] stable_dly_q;
  logic [7:0] deb_cnt_q [2];
  logic [7:0] deb_cnt_d [2];
  logic [1:0] rise;
  logic [1:0] pend_q, pend_d, pend_clr;

  logic [1:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic       conflict_d;
  logic       s_q, r_q, busy_q, conflict_q;

  assign raw = {clr_in, set_in};

  // Debounce: the counter tracks how long sync has disagreed with stable.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i]  = stable_q[i];
      deb_cnt_d[i] = 8'd0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] + 8'd1 == DebMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    pend_clr   = 2'b00;
    conflict_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pend_q == 2'b11) begin
          // Both pending: winner is driven, loser is dropped.
          pend_clr   = 2'b11;
          conflict_d = 1'b1;
          state_d    = CLR_PRIORITY ? StDriveR : StDriveS;
          hold_d     = 8'd0;
          cnt_d      = cnt_q + 8'd1;
        end else if (pend_q[0]) begin
          pend_clr = 2'b01;
          state_d  = StDriveS;
          hold_d   = 8'd0;
          cnt_d    = cnt_q + 8'd1;
        end else if (pend_q[1]) begin
          pend_clr = 2'b10;
          state_d  = StDriveR;
          hold_d   = 8'd0;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      StDriveS, StDriveR: begin
        if (hold_q == HoldMax) begin
          state_d = StGap;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A fresh edge is never lost, even in the cycle its channel is accepted.
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      stable_q     <= 2'b00;
      stable_dly_q <= 2'b00;
      deb_cnt_q[0] <= 8'd0;
      deb_cnt_q[1] <= 8'd0;
      pend_q       <= 2'b00;
      state_q      <= StIdle;
      hold_q       <= 8'd0;
      cnt_q        <= 8'd0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      busy_q       <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      pend_q       <= pend_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      // Outputs are registered from the next state so they align with it.
      s_q          <= (state_d == StDriveS);
      r_q          <= (state_d == StDriveR);
      busy_q       <= (state_d != StIdle);
      conflict_q   <= conflict_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign conflict  = conflict_q;
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen with default parameters.
// A history-based model predicts outputs every cycle; directed scenarios
// add literal expectations at hand-computed edges.
module tb_sr_cmd_gen;

  localparam int Deb  = 4;
  localparam int Hold = 2;
  localparam int HistLen = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set_in = 1'b0;
  logic       clr_in = 1'b0;
  logic       s, r, busy, conflict;
  logic [7:0] cmd_count;

  int checks = 0;
  int errors = 0;

  sr_cmd_gen dut (
    .clk       (clk),
    .reset     (reset),
    .set_in    (set_in),
    .clr_in    (clr_in),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .conflict  (conflict),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Histories indexed by edge number since reset release: raw sample taken
  // at the edge, synchronized value after the edge, stable level after it.
  logic raw_h [2][HistLen];
  logic syn_h [2][HistLen];
  logic st_h  [2][HistLen];
  int   n = 0;
  logic [1:0] m_pend = 2'b00;
  int   free_edge = 0, drv_end = -1, busy_end = -1, conf_edge = -1, drv_ch = 0;
  int   m_cnt = 0;
  logic exp_s = 0, exp_r = 0, exp_busy = 0, exp_conf = 0;
  logic [7:0] exp_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; m_pend = 2'b00; free_edge = 0; drv_end = -1; busy_end = -1;
      conf_edge = -1; drv_ch = 0; m_cnt = 0;
      exp_s = 0; exp_r = 0; exp_busy = 0; exp_conf = 0; exp_cnt = 0;
    end else begin
      logic [1:0] rise;
      logic [1:0] accept;
      raw_h[0][n] = set_in;
      raw_h[1][n] = clr_in;
      for (int c = 0; c < 2; c++) begin
        logic old, all_diff, v, p1, p2;
        syn_h[c][n] = (n >= 1) ? raw_h[c][n-1] : 1'b0;
        old = (n >= 1) ? st_h[c][n-1] : 1'b0;
        // Level flips once the last Deb synchronized samples all disagree.
        all_diff = 1'b1;
        for (int d = 1; d <= Deb; d++) begin
          v = (n - d >= 0) ? syn_h[c][n-d] : 1'b0;
          if (v == old) all_diff = 1'b0;
        end
        st_h[c][n] = all_diff ? ~old : old;
        p1 = (n >= 1) ? st_h[c][n-1] : 1'b0;
        p2 = (n >= 2) ? st_h[c][n-2] : 1'b0;
        rise[c] = p1 & ~p2;
      end
      accept = 2'b00;
      if (n >= free_edge && m_pend != 2'b00) begin
        if (m_pend == 2'b11) begin
          drv_ch = 1;  // clear has priority
          accept = 2'b11;
          conf_edge = n;
        end else begin
          drv_ch = m_pend[1] ? 1 : 0;
          accept = m_pend;
        end
        drv_end   = n + Hold - 1;
        busy_end  = n + Hold;
        free_edge = n + Hold + 2;
        m_cnt     = (m_cnt + 1) % 256;
      end
      m_pend   = (m_pend & ~accept) | rise;
      exp_s    = (drv_ch == 0) && (n <= drv_end);
      exp_r    = (drv_ch == 1) && (n <= drv_end);
      exp_busy = (n <= busy_end);
      exp_conf = (n == conf_edge);
      exp_cnt  = 8'(m_cnt);
      n++;
    end
  end

  always @(negedge clk) begin
    chk("m_s", {31'd0, s}, {31'd0, exp_s});
    chk("m_r", {31'd0, r}, {31'd0, exp_r});
    chk("m_busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("m_conflict", {31'd0, conflict}, {31'd0, exp_conf});
    chk("m_cmd_count", {24'd0, cmd_count}, {24'd0, exp_cnt});
    chk("m_s_and_r", {31'd0, s & r}, 32'd0);
  end

  // ---------------- directed scenarios ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0; set_in = 1'b0; clr_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_s"}, {31'd0, s}, 32'd0);
    chk({tag, "_r"}, {31'd0, r}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_conflict"}, {31'd0, conflict}, 32'd0);
    chk({tag, "_cmd_count"}, {24'd0, cmd_count}, 32'd0);
  endtask

  initial begin
    // 1: reset held with random inputs, then release with inputs low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in = 1'($urandom);
      clr_in = 1'($urandom);
      @(posedge clk); #1;
      chk_idle("t1_rst");
    end
    @(negedge clk); set_in = 1'b0; clr_in = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_idle("t1_rel");
    end

    // 2: clean set request held 12 cycles.
    do_reset();
    @(negedge clk); set_in = 1'b1;
    @(posedge clk);  // edge 0
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_s_e%0d", j), {31'd0, s}, {31'd0, (j == 7 || j == 8)});
      chk($sformatf("t2_busy_e%0d", j), {31'd0, busy}, {31'd0, (j >= 7 && j <= 9)});
      chk($sformatf("t2_r_e%0d", j), {31'd0, r}, 32'd0);
      if (j == 11) set_in = 1'b0;
    end
    repeat (6) @(posedge clk); #1;
    chk("t2_cmd_count", {24'd0, cmd_count}, 32'd1);

    // 3: glitches of 3 cycles are rejected.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); set_in = 1'b1;
      repeat (3) @(negedge clk);
      set_in = 1'b0;
      repeat (3) @(posedge clk);
    end
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      chk("t3_s", {31'd0, s}, 32'd0);
    end
    chk("t3_cmd_count", {24'd0, cmd_count}, 32'd0);

    // 4: simultaneous requests, clear wins.
    do_reset();
    @(negedge clk); set_in = 1'b1; clr_in = 1'b1;
    @(posedge clk);  // edge 0
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_r_e%0d", j), {31'd0, r}, {31'd0, (j == 7 || j == 8)});
      chk($sformatf("t4_conflict_e%0d", j), {31'd0, conflict}, {31'd0, (j == 7)});
      chk($sformatf("t4_s_e%0d", j), {31'd0, s}, 32'd0);
    end
    chk("t4_cmd_count", {24'd0, cmd_count}, 32'd1);

    // 5: clear edge lands while DRIVE_S is active.
    do_reset();
    @(negedge clk); set_in = 1'b1;
    @(posedge clk);  // edge 0
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      if (j == 1) clr_in = 1'b1;
      chk($sformatf("t5_s_e%0d", j), {31'd0, s}, {31'd0, (j == 7 || j == 8)});
      chk($sformatf("t5_r_e%0d", j), {31'd0, r}, {31'd0, (j == 11 || j == 12)});
    end
    chk("t5_cmd_count", {24'd0, cmd_count}, 32'd2);

    // 6: asynchronous reset in the second DRIVE_S cycle.
    do_reset();
    @(negedge clk); set_in = 1'b1;
    @(posedge clk);  // edge 0
    repeat (7) @(posedge clk); #1;
    chk("t6_s_edge7", {31'd0, s}, 32'd1);
    @(posedge clk); #2;  // second DRIVE_S cycle
    reset = 1'b0; set_in = 1'b0;
    #1;
    chk_idle("t6_async");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      chk_idle("t6_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
